serial_add_host: RTL and testbench
==================================

// Module: serial_add_host
// PURPOSE
//  Host-side driver for the bit-serial adder FSM (ports CIN/A/B/start/rst/S/COUT).
//  Accepts parallel operands on a valid/ready request port and shifts them LSB-first into the adder.
//  Collects the S bitstream and the final COUT into a parallel result on a valid/ready response port.
//  Replaces vector-file stimulus with a synthesizable initiator, so the adder can be used in datapaths.
// PARAMETERS
//  WIDTH  8  operand/sum width in bits (>=1)
// PORTS
//  CLK        in   1      single clock, rising edge
//  NRST       in   1      asynchronous active-low reset
//  rst        in   1      synchronous abort: return to IDLE next edge
//  req_valid  in   1      operand request valid
//  req_ready  out  1      host can accept a request (IDLE only)
//  op_a       in   WIDTH  operand A
//  op_b       in   WIDTH  operand B
//  op_cin     in   1      carry-in
//  ser_rst    out  1      to adder rst: clears the adder carry
//  ser_start  out  1      to adder start: marks bit 0
//  ser_a      out  1      to adder A, current bit
//  ser_b      out  1      to adder B, current bit
//  ser_cin    out  1      to adder CIN, valid with ser_start
//  ser_s      in   1      from adder S: Mealy, valid in the same cycle as ser_a/ser_b
//  ser_cout   in   1      from adder COUT: carry-out of the current bit, same cycle
//  rsp_valid  out  1      result valid, held until accepted
//  rsp_ready  in   1      result consumer ready
//  rsp_sum    out  WIDTH  collected sum
//  rsp_cout   out  1      final carry-out
// BEHAVIOUR
//  - NRST=0: state IDLE; req_ready=1; all ser_*=0; rsp_valid=0; rsp_sum=0; rsp_cout=0; bit count=0.
//  - FSM IDLE -> CLEAR -> SHIFT -> DONE -> IDLE.
//    IDLE: req_ready=1. On req_valid at edge t, latch op_a, op_b and op_cin, then go to CLEAR.
//    CLEAR (cycle t+1): ser_rst=1, other ser_* outputs 0.
//    SHIFT (cycles t+2 .. t+1+WIDTH):
//      - Drive bit i on ser_a/ser_b; ser_start=1 and ser_cin=op_cin only when i=0.
//      - Sample ser_s into rsp_sum[i] at the end of each SHIFT cycle.
//      - At i=WIDTH-1, also sample ser_cout into rsp_cout, then go to DONE.
//    DONE (from t+2+WIDTH): rsp_valid=1; rsp_sum and rsp_cout are stable.
//      - When rsp_valid && rsp_ready, go to IDLE. A new request is accepted no earlier than the next edge.
//  - Latency: request accept to rsp_valid is WIDTH+2 cycles. Throughput is one op per WIDTH+3 cycles.
//  - Outside SHIFT: ser_a, ser_b, ser_cin and ser_start are 0. req_ready=0 everywhere except IDLE.
//  - Bit counter is $clog2(WIDTH) bits wide (min 1). WIDTH=1: SHIFT lasts one cycle, with start=1 on that bit.
//  - Sum is modulo 2^WIDTH; the overflow bit appears only on rsp_cout.
//  - req_valid outside IDLE is ignored; operands are not re-sampled mid-operation.
//  - rst=1 in any state:
//      - Go to IDLE at the next edge; rsp_valid=0; partial sum discarded (rsp_sum cleared to 0).
//      - ser_rst=1 for that single cycle, to clear the adder.
//      - rst has priority over a simultaneous req_valid or rsp_ready.
//  - NRST asserted mid-operation: immediate return to the reset values; no response is produced.
//  - rsp_ready held low: stay in DONE indefinitely, outputs unchanged.
// STRUCTURE
//  - serial_add_pkg: state enum (IDLE, CLEAR, SHIFT, DONE) with 2-bit encoding; the bit-count width function.
//  - One sub-module, serial_shreg:
//      - WIDTH-bit shift register with load, shift-right and serial-in at the MSB.
//      - Instantiated twice: a packed {a,b} operand register, and the sum collector.
//  - Top level holds the FSM, the bit counter and the cout flag.
// TESTING (bench pairs the DUT with the serial adder and a reference a+b+cin model)
//  1. op_a=8'hFF, op_b=8'h01, cin=0 -> rsp_sum=8'h00, rsp_cout=1, rsp_valid 10 cycles after accept.
//  2. op_a=8'h5A, op_b=8'hA5, cin=1 -> rsp_sum=8'h00, rsp_cout=1; ser_start high only on bit 0.
//  3. op_a=8'h00, op_b=8'h00, cin=0, with rsp_ready low for 5 cycles -> rsp_valid held, sum 8'h00 stable;
//     req_ready stays 0 until the handshake completes.
//  4. rst pulsed at SHIFT bit 3 of 8'h12+8'h34 -> IDLE next cycle, rsp_valid never asserts.
//     Next request 8'h12+8'h34 -> 8'h46, cout 0.
//  5. NRST dropped mid-SHIFT -> all outputs take reset values asynchronously; recovery op 8'h80+8'h80 -> 8'h00, cout 1.
//  6. 1000 random op/cin back-to-back, rsp_ready random -> every result matches the model; no lost or duplicated responses.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder host.
//   state_e   : host FSM states (2-bit encoding)
//   cnt_width : bit-counter width for a given operand width (never below 1)
package serial_add_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StClear = 2'd1,
    StShift = 2'd2,
    StDone  = 2'd3
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_shreg.sv
// Shift register of WIDTH elements, each LANES bits wide, shifting right by one element.
//   CLK, NRST : clock, asynchronous active-low reset
//   i_clr     : synchronous clear (highest priority)
//   i_load    : parallel load of i_data
//   i_shift   : shift right one element, i_ser enters at the MSB element
//   o_q       : register contents; element 0 (LSBs) is the next element out
module serial_shreg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 1
) (
  input  logic                   CLK,
  input  logic                   NRST,
  input  logic                   i_clr,
  input  logic                   i_load,
  input  logic [WIDTH*LANES-1:0] i_data,
  input  logic                   i_shift,
  input  logic [LANES-1:0]       i_ser,
  output logic [WIDTH*LANES-1:0] o_q
);

  logic [WIDTH*LANES-1:0] r_q;
  logic [WIDTH*LANES-1:0] w_shifted;

  generate
    if (WIDTH == 1) begin : g_single
      assign w_shifted = i_ser;
    end else begin : g_multi
      assign w_shifted = {i_ser, r_q[WIDTH*LANES-1:LANES]};
    end
  endgenerate

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_data;
    end else if (i_shift) begin
      r_q <= w_shifted;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/serial_add_host.sv
// Host-side driver for a bit-serial adder: takes parallel operands on a valid/ready request port,
// feeds them LSB-first into the adder, and returns the collected sum and final carry on a
// valid/ready response port.
//   CLK, NRST            : clock, asynchronous active-low reset
//   rst                  : synchronous abort back to idle (clears the adder carry)
//   req_*, op_*          : operand request handshake and operands
//   ser_*                : adder interface (rst/start/A/B/CIN out, S/COUT in)
//   rsp_*                : result handshake, sum and carry-out
module serial_add_host
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             NRST,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic             ser_rst,
  output logic             ser_start,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_cin,
  input  logic             ser_s,
  input  logic             ser_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout
);

  localparam int unsigned     CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e                 r_state;
  logic   [CntW-1:0]      r_cnt;
  logic                   r_cin;
  logic                   r_cout;
  logic                   r_ser_rst;

  logic                   w_accept;
  logic                   w_shift_en;
  logic [2*WIDTH-1:0]     w_op_pack;
  logic [2*WIDTH-1:0]     w_op_q;

  assign w_accept   = (r_state == StIdle) && req_valid && !rst;
  assign w_shift_en = (r_state == StShift) && !rst;

  // Interleave operands so each 2-bit element is {a[i], b[i]} and one shift presents both bits.
  always_comb begin
    w_op_pack = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      w_op_pack[2*i+1] = op_a[i];
      w_op_pack[2*i]   = op_b[i];
    end
  end

  serial_shreg #(
    .WIDTH (WIDTH),
    .LANES (2)
  ) u_op_reg (
    .CLK     (CLK),
    .NRST    (NRST),
    .i_clr   (rst),
    .i_load  (w_accept),
    .i_data  (w_op_pack),
    .i_shift (w_shift_en),
    .i_ser   (2'b00),
    .o_q     (w_op_q)
  );

  // Sum bits arrive LSB-first at the MSB; after WIDTH shifts bit 0 has reached position 0.
  serial_shreg #(
    .WIDTH (WIDTH),
    .LANES (1)
  ) u_sum_reg (
    .CLK     (CLK),
    .NRST    (NRST),
    .i_clr   (rst || w_accept),
    .i_load  (1'b0),
    .i_data  ('0),
    .i_shift (w_shift_en),
    .i_ser   (ser_s),
    .o_q     (rsp_sum)
  );

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_cin     <= 1'b0;
      r_cout    <= 1'b0;
      r_ser_rst <= 1'b0;
    end else if (rst) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_cin     <= 1'b0;
      r_cout    <= 1'b0;
      r_ser_rst <= 1'b1;
    end else begin
      r_ser_rst <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (req_valid) begin
            r_cin     <= op_cin;
            r_cout    <= 1'b0;
            r_ser_rst <= 1'b1;
            r_state   <= StClear;
          end
        end
        StClear: begin
          r_cnt   <= '0;
          r_state <= StShift;
        end
        StShift: begin
          if (r_cnt == LastCnt) begin
            r_cout  <= ser_cout;
            r_cnt   <= '0;
            r_state <= StDone;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StDone: begin
          if (rsp_ready) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign req_ready = (r_state == StIdle);
  assign rsp_valid = (r_state == StDone);
  assign rsp_cout  = r_cout;
  assign ser_rst   = r_ser_rst;
  assign ser_start = (r_state == StShift) && (r_cnt == '0);
  assign ser_cin   = ser_start && r_cin;
  assign ser_a     = (r_state == StShift) && w_op_q[1];
  assign ser_b     = (r_state == StShift) && w_op_q[0];

endmodule

// File: tb/tb_serial_add_host.sv
// Bench for serial_add_host: pairs the host with a behavioural bit-serial adder and checks results
// against an a+b+cin reference through a scoreboard queue.
module tb_serial_add_host;

  localparam int unsigned WIDTH = 8;

  logic             CLK = 1'b0;
  logic             NRST;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic             ser_rst;
  logic             ser_start;
  logic             ser_a;
  logic             ser_b;
  logic             ser_cin;
  logic             ser_s;
  logic             ser_cout;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;

  serial_add_host #(
    .WIDTH (WIDTH)
  ) dut (
    .CLK       (CLK),
    .NRST      (NRST),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_cin    (op_cin),
    .ser_rst   (ser_rst),
    .ser_start (ser_start),
    .ser_a     (ser_a),
    .ser_b     (ser_b),
    .ser_cin   (ser_cin),
    .ser_s     (ser_s),
    .ser_cout  (ser_cout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout)
  );

  always #5 CLK = ~CLK;

  // Behavioural Mealy serial adder: CIN replaces the stored carry on the start bit.
  logic r_carry;
  logic w_c;
  always_comb begin
    w_c      = ser_start ? ser_cin : r_carry;
    ser_s    = ser_a ^ ser_b ^ w_c;
    ser_cout = (ser_a & ser_b) | (ser_a & w_c) | (ser_b & w_c);
  end
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST)        r_carry <= 1'b0;
    else if (ser_rst) r_carry <= 1'b0;
    else              r_carry <= ser_cout;
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_rsp    = 0;
  int n_start  = 0;
  logic [WIDTH:0] sb_q[$];
  logic [WIDTH:0] m_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: push on accepted request, pop on accepted response; aborts drop the pending entry.
  always @(negedge CLK) begin
    if (!NRST || rst) begin
      sb_q.delete();
    end else begin
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          m_exp = sb_q.pop_front();
          check("rsp_sum", 32'(rsp_sum), 32'(m_exp[WIDTH-1:0]));
          check("rsp_cout", 32'(rsp_cout), 32'(m_exp[WIDTH]));
          n_rsp++;
        end
      end
      if (req_valid && req_ready) begin
        sb_q.push_back({1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, op_cin});
      end
      if (ser_start) n_start++;
    end
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin);
    bit ok = 1'b0;
    op_a      = a;
    op_b      = b;
    op_cin    = cin;
    req_valid = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("req_timeout", 32'd0, 32'd1);
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp_done();
    bit ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge CLK);
      if (rsp_valid && rsp_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("rsp_timeout", 32'd0, 32'd1);
    @(posedge CLK);
    #1;
  endtask

  int  lat;
  int  s0;
  int  r0;
  bit  seen;
  bit  done;

  initial begin
    NRST      = 1'b1;
    rst       = 1'b0;
    req_valid = 1'b0;
    op_a      = '0;
    op_b      = '0;
    op_cin    = 1'b0;
    rsp_ready = 1'b1;
    #3 NRST = 1'b0;
    #9;
    check("reset_ctrl", {req_ready, rsp_valid, rsp_cout}, 3'b100);
    check("reset_sum", 32'(rsp_sum), 32'd0);
    check("reset_ser", {ser_rst, ser_start, ser_a, ser_b, ser_cin}, 5'b00000);
    @(negedge CLK);
    NRST = 1'b1;
    @(posedge CLK);
    #1;

    // 1: FF+01, latency and CLEAR-cycle outputs
    send(8'hFF, 8'h01, 1'b0);
    @(negedge CLK);
    check("clear_ser_rst", 32'(ser_rst), 32'd1);
    check("clear_ser_quiet", {ser_start, ser_a, ser_b, ser_cin, req_ready}, 5'b00000);
    lat = -1;
    for (int k = 2; k <= 40; k++) begin
      @(negedge CLK);
      if (rsp_valid) begin
        lat = k;
        break;
      end
    end
    check("latency", 32'(lat), WIDTH + 2);
    @(posedge CLK);
    #1;
    check("idle_after_rsp", {req_ready, rsp_valid}, 2'b10);

    // 2: 5A+A5+1, start only on bit 0 with CIN
    s0 = n_start;
    send(8'h5A, 8'hA5, 1'b1);
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (ser_start) begin
        seen = 1'b1;
        break;
      end
    end
    check("start_seen", 32'(seen), 32'd1);
    check("start_bits", {ser_cin, ser_a, ser_b}, 3'b101);
    wait_rsp_done();
    check("start_count", 32'(n_start - s0), 32'd1);

    // 3: 00+00 with rsp_ready held low
    rsp_ready = 1'b0;
    send(8'h00, 8'h00, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("hold_valid_seen", 32'(seen), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check("hold", {rsp_valid, req_ready, rsp_cout, rsp_sum}, {3'b100, 8'h00});
      @(negedge CLK);
    end
    @(posedge CLK);
    #1;
    rsp_ready = 1'b1;
    wait_rsp_done();
    check("hold_released", {req_ready, rsp_valid}, 2'b10);

    // 4: abort at SHIFT bit 3, then rerun
    send(8'h12, 8'h34, 1'b0);
    repeat (4) @(posedge CLK);
    #1;
    rst = 1'b1;
    @(posedge CLK);
    #1;
    rst = 1'b0;
    check("abort_state", {req_ready, rsp_valid, rsp_cout, rsp_sum}, {3'b100, 8'h00});
    seen = 1'b0;
    repeat (15) begin
      @(negedge CLK);
      if (rsp_valid) seen = 1'b1;
    end
    check("abort_no_rsp", 32'(seen), 32'd0);
    send(8'h12, 8'h34, 1'b0);
    wait_rsp_done();

    // 5: asynchronous reset mid-SHIFT, then recovery
    send(8'hFF, 8'hFF, 1'b1);
    repeat (4) @(posedge CLK);
    #2 NRST = 1'b0;
    #1;
    check("nrst_ctrl", {req_ready, rsp_valid, rsp_cout}, 3'b100);
    check("nrst_sum", 32'(rsp_sum), 32'd0);
    check("nrst_ser", {ser_rst, ser_start, ser_a, ser_b, ser_cin}, 5'b00000);
    @(negedge CLK);
    #1 NRST = 1'b1;
    @(posedge CLK);
    #1;
    send(8'h80, 8'h80, 1'b0);
    wait_rsp_done();

    // 6: random back-to-back traffic with random rsp_ready
    r0   = n_rsp;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
        end
        for (int k = 0; k < 300; k++) begin
          @(negedge CLK);
          if (sb_q.size() == 0) break;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge CLK);
          #1;
          rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    rsp_ready = 1'b1;
    check("rand_rsp_count", 32'(n_rsp - r0), 32'd1000);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
